// File: rtl/memory_game_pkg.sv
// Shared constants, FSM state type and LFSR step for the sequence writer.
package memory_game_pkg;

    localparam int         DEPTH     = 10;
    localparam int         DATA_W    = 4;
    localparam int         ADDR_W    = 4;
    localparam logic [3:0] LFSR_SEED = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        FULL  = 2'd3
    } state_t;

    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus single-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    // sync[0..1] resynchronize, sync[2] holds the previous synchronized level
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], btn};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/memory_seq_writer.sv
// Writes a sequence of entries into BRAM, either one per btn0 press from the
// switches or auto-filled from an LFSR on btn1; btn1 in FULL clears the sequence.
//
// state | meaning
// IDLE  | waiting for a button edge
// WRITE | single manual write of the latched switch value
// FILL  | one LFSR entry written per cycle up to DEPTH-1
// FULL  | sequence complete; only btn1 (clear) is honoured
module memory_seq_writer #(
    parameter int         DEPTH     = memory_game_pkg::DEPTH,
    parameter int         DATA_W    = memory_game_pkg::DATA_W,
    parameter int         ADDR_W    = memory_game_pkg::ADDR_W,
    parameter logic [3:0] LFSR_SEED = memory_game_pkg::LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] switches,
    input  logic              btn0,
    input  logic              btn1,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [3:0]        seq_len,
    output logic              busy,
    output logic              done
);

    import memory_game_pkg::*;

    state_t            state, state_nxt;
    logic              rise0, rise1;
    logic [ADDR_W-1:0] wr_ptr;
    logic [3:0]        len_q;
    logic [DATA_W-1:0] entry_q;
    logic [3:0]        lfsr;
    logic              last_entry;

    btn_sync_edge u_sync_btn0 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn0),
        .rise  (rise0)
    );

    btn_sync_edge u_sync_btn1 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn1),
        .rise  (rise1)
    );

    assign last_entry = (wr_ptr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // btn0 wins over btn1 in IDLE; edges seen in WRITE/FILL are simply dropped
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise0) state_nxt = WRITE;
                     else if (rise1) state_nxt = FILL;
            WRITE:   state_nxt = last_entry ? FULL : IDLE;
            FILL:    if (last_entry) state_nxt = FULL;
            FULL:    if (rise1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            len_q   <= 4'd0;
            entry_q <= '0;
            lfsr    <= LFSR_SEED;
        end else begin
            if (state == IDLE && rise0) begin
                entry_q <= switches;
            end
            if (state == WRITE || state == FILL) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                len_q  <= len_q + 4'd1;
            end
            if (state == FILL) begin
                lfsr <= lfsr_next(lfsr);
            end
            if (state == FULL && rise1) begin
                wr_ptr <= '0;
                len_q  <= 4'd0;
                lfsr   <= LFSR_SEED;
            end
        end
    end

    always_comb begin
        bram_din = '0;
        if (state == WRITE) begin
            bram_din = entry_q;
        end else if (state == FILL) begin
            bram_din = DATA_W'(lfsr);
        end
    end

    assign busy      = (state == WRITE) || (state == FILL);
    assign bram_we   = busy;
    assign done      = (state == FULL);
    assign bram_addr = wr_ptr;
    assign seq_len   = len_q;

endmodule

// File: doc/memory_seq_writer.md
MEMORY_SEQ_WRITER -- requirements
Module: memory_seq_writer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 10, SHALL set the number of sequence entries, in the range 1..15.
REQ-003 Parameter DATA_W, default 4, SHALL set the entry width.
REQ-004 Parameter ADDR_W, default 4, SHALL set the BRAM address width.
REQ-005 Parameter LFSR_SEED, default 4'b1010, SHALL set the nonzero auto-fill seed.
REQ-006 Port clk, input, 1: SHALL be the system clock; all state is on its rising edge.
REQ-007 Port rst_n, input, 1: SHALL be the asynchronous active-low reset.
REQ-008 Port switches, input, DATA_W: SHALL carry the entry value for a manual write.
REQ-009 Port btn0, input, 1: SHALL be the raw, asynchronous commit-entry button.
REQ-010 Port btn1, input, 1: SHALL be the raw auto-fill/clear button.
REQ-011 Port bram_we, output, 1: SHALL be the BRAM write enable, one-cycle pulse per entry.
REQ-012 Port bram_addr, output, ADDR_W: SHALL be the BRAM write address.
REQ-013 Port bram_din, output, DATA_W: SHALL be the BRAM write data.
REQ-014 Port seq_len, output, 4: SHALL give the number of entries written, 0..DEPTH.
REQ-015 Port busy, output, 1: SHALL be high in WRITE and FILL.
REQ-016 Port done, output, 1: SHALL be high in FULL.

Function
REQ-017 btn0 and btn1 SHALL each pass a 2-flop synchronizer followed by rising-edge detection; a held button SHALL yield exactly one edge.
REQ-018 The FSM states SHALL be IDLE, WRITE, FILL and FULL.
REQ-019 A btn0 edge in IDLE SHALL register switches and move to WRITE; bram_we SHALL be high on the 3rd rising clk edge after btn0 is sampled high.
REQ-020 WRITE SHALL last one cycle, driving bram_we=1, bram_addr=wr_ptr and bram_din=the latched value.
REQ-021 On leaving WRITE, wr_ptr and seq_len SHALL increment; the FSM SHALL go to FULL if wr_ptr was DEPTH-1, otherwise to IDLE.
REQ-022 A btn1 edge in IDLE SHALL enter FILL.
REQ-023 FILL SHALL write one entry per cycle at wr_ptr..DEPTH-1, with bram_din equal to the current LFSR value; the LFSR SHALL advance after each write.
REQ-024 FILL SHALL then go to FULL, with seq_len=DEPTH.
REQ-025 The LFSR SHALL be a 4-bit Fibonacci LFSR, next = {q[2:0], q[3]^q[2]}, that advances only on FILL writes.
REQ-026 In FULL, btn0 edges SHALL be ignored.
REQ-027 A btn1 edge in FULL SHALL clear wr_ptr, seq_len and the LFSR (to LFSR_SEED), perform no write, and return to IDLE.
REQ-028 Simultaneous btn0 and btn1 edges in IDLE SHALL perform the manual write only; the btn1 edge SHALL be discarded.
REQ-029 Edges arriving in WRITE or FILL SHALL be discarded, not queued.
REQ-030 bram_we SHALL be 0 whenever the FSM is not in WRITE or FILL.
REQ-031 bram_addr SHALL equal wr_ptr at all times.

Reset
REQ-032 rst_n low SHALL immediately force bram_we=0, bram_addr=0, bram_din=0, seq_len=0, busy=0, done=0, state=IDLE, LFSR=LFSR_SEED, and clear the synchronizer and edge flops.
REQ-033 Reset asserted mid-FILL SHALL abort the fill with no further writes; after release the block SHALL resume in IDLE at address 0.

Structure
REQ-034 DEPTH, DATA_W, ADDR_W, LFSR_SEED and the state enum SHALL live in the shared package memory_game_pkg.
REQ-035 Synchronizer plus edge detect SHALL be the sub-module btn_sync_edge, instantiated once per button.

Verification
REQ-036 The bench SHALL cover manual writes: switches=1010 with a btn0 pulse -> one bram_we pulse at addr 0, din 1010, seq_len=1; then switches=0110 with btn0 -> addr 1, din 0110, seq_len=2.
REQ-037 The bench SHALL cover auto-fill: after the 2 manual entries, a btn1 pulse -> 8 consecutive bram_we cycles at addr 2..9 with din 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000; then done=1 and seq_len=10.
REQ-038 The bench SHALL cover FULL: a btn0 pulse -> no bram_we; a btn1 pulse -> done=0, seq_len=0, bram_addr=0, no bram_we.
REQ-039 The bench SHALL cover simultaneous and held presses: btn0 and btn1 rising in the same cycle in IDLE -> exactly one write of switches, state IDLE; btn0 held 50 cycles -> exactly one write.
REQ-040 The bench SHALL cover reset mid-FILL: rst_n low during the 3rd fill write -> all outputs 0 at once; after release a btn0 write goes to addr 0.
